// File: rtl/jtopl_pg_sched_pkg.sv
// Shared slot-frame widths and slot -> channel/operator decode for the PG scheduler.
// The frame is every modulator in channel order, then every carrier in channel order.
package jtopl_pg_sched_pkg;

    localparam int SLOT_W = 5;
    localparam int CH_W   = 4;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            op;
    } slot_dec_t;

    function automatic slot_dec_t slot_decode(input logic [SLOT_W-1:0] slot, input int ch_n);
        slot_dec_t d;
        if (slot >= SLOT_W'(ch_n)) begin
            d.op = 1'b1;
            d.ch = CH_W'(slot - SLOT_W'(ch_n));
        end else begin
            d.op = 1'b0;
            d.ch = CH_W'(slot);
        end
        return d;
    endfunction

    function automatic logic [SLOT_W-1:0] slot_next(input logic [SLOT_W-1:0] slot, input int ch_n);
        return (slot == SLOT_W'(2 * ch_n - 1)) ? '0 : slot + 1'b1;
    endfunction

endpackage

// File: rtl/jtopl_pg_sched_if.sv
// Operator-clock / key-on write inputs and per-slot scheduling outputs of the PG scheduler.
interface jtopl_pg_sched_if;
    logic       cenop;
    logic       up_kon;
    logic [3:0] kon_ch;
    logic       kon_val;
    logic [4:0] slot_I;
    logic [3:0] ch_I;
    logic       op_I;
    logic       kon_I;
    logic       pg_rst_I;
    logic       zero;

    modport master (
        output cenop, up_kon, kon_ch, kon_val,
        input  slot_I, ch_I, op_I, kon_I, pg_rst_I, zero
    );

    modport slave (
        input  cenop, up_kon, kon_ch, kon_val,
        output slot_I, ch_I, op_I, kon_I, pg_rst_I, zero
    );
endinterface

// File: rtl/jtopl_pg_sched_slot_cnt.sv
// Slot counter: advances on cen_i, wraps at 2*CH-1; also exposes the slot it will move to next.
module jtopl_slot_cnt
    import jtopl_pg_sched_pkg::*;
#(
    parameter int CH = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic [SLOT_W-1:0] next_o,
    output logic [CH_W-1:0]   ch_o,
    output logic              op_o,
    output logic              zero_o
);

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;
    slot_dec_t         dec;

    assign slot_d = slot_next(slot_q, CH);

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_q <= '0;
        end else if (cen_i) begin
            slot_q <= slot_d;
        end
    end

    assign dec    = slot_decode(slot_q, CH);
    assign slot_o = slot_q;
    assign next_o = slot_d;
    assign ch_o   = dec.ch;
    assign op_o   = dec.op;
    assign zero_o = (slot_q == '0);

endmodule

// File: rtl/jtopl_pg_sched.sv
// Key-on mask and per-slot pending phase-reset scheduling; pg_rst_I/kon_I are registered on each slot advance.
// Key-on writes are taken on any clk, the slot pipeline moves only with cenop.
module jtopl_pg_sched
    import jtopl_pg_sched_pkg::*;
#(
    parameter int CH = 9
) (
    input  logic             clk,
    input  logic             rst,
    jtopl_pg_sched_if.slave  bus
);

    logic [SLOT_W-1:0] nxt_slot;
    slot_dec_t         nxt_dec;
    logic [CH-1:0]     kon_q, kon_d;
    logic [2*CH-1:0]   pend_q, pend_d;
    logic              kon_out_q, kon_out_d;
    logic              pg_q, pg_d;
    logic              wr_vld;
    logic [SLOT_W-1:0] mod_idx, car_idx;

    jtopl_slot_cnt #(.CH(CH)) u_slot_cnt (
        .clk    (clk),
        .rst    (rst),
        .cen_i  (bus.cenop),
        .slot_o (bus.slot_I),
        .next_o (nxt_slot),
        .ch_o   (bus.ch_I),
        .op_o   (bus.op_I),
        .zero_o (bus.zero)
    );

    assign nxt_dec = slot_decode(nxt_slot, CH);
    assign wr_vld  = bus.up_kon && (bus.kon_ch < CH_W'(CH));
    assign mod_idx = SLOT_W'(bus.kon_ch);
    assign car_idx = SLOT_W'(bus.kon_ch) + SLOT_W'(CH);

    // Service is applied before the write so a key-on landing on the serviced slot keeps its pending bit.
    always_comb begin
        pend_d    = pend_q;
        kon_d     = kon_q;
        kon_out_d = kon_out_q;
        pg_d      = pg_q;
        if (bus.cenop) begin
            pg_d             = pend_q[nxt_slot];
            kon_out_d        = kon_q[nxt_dec.ch];
            pend_d[nxt_slot] = 1'b0;
        end
        if (wr_vld) begin
            if (bus.kon_val && !kon_q[bus.kon_ch]) begin
                pend_d[mod_idx] = 1'b1;
                pend_d[car_idx] = 1'b1;
            end else if (!bus.kon_val) begin
                pend_d[mod_idx] = 1'b0;
                pend_d[car_idx] = 1'b0;
            end
            kon_d[bus.kon_ch] = bus.kon_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            kon_q     <= '0;
            pend_q    <= '0;
            kon_out_q <= 1'b0;
            pg_q      <= 1'b0;
        end else begin
            kon_q     <= kon_d;
            pend_q    <= pend_d;
            kon_out_q <= kon_out_d;
            pg_q      <= pg_d;
        end
    end

    assign bus.kon_I    = kon_out_q;
    assign bus.pg_rst_I = pg_q;

endmodule
